// File: rtl/control_unit.sv
// Main decoder of the microRISC single-cycle core: combinational opcode/funct decode
// into datapath controls, plus a sticky illegal-instruction flag.
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic [2:0] funct,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic [3:0] alu_op,
  output logic [1:0] reg_dst,
  output logic       branch,
  output logic       branch_ne,
  output logic       jump,
  output logic       jump_reg,
  output logic       link,
  output logic       illegal,
  output logic       illegal_seen
);

  localparam logic [3:0] OP_R_TYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI   = 4'b0001;
  localparam logic [3:0] OP_LW     = 4'b0010;
  localparam logic [3:0] OP_SW     = 4'b0011;
  localparam logic [3:0] OP_BEQ    = 4'b0100;
  localparam logic [3:0] OP_BNE    = 4'b0101;
  localparam logic [3:0] OP_J      = 4'b0110;
  localparam logic [3:0] OP_JAL    = 4'b0111;
  localparam logic [3:0] OP_JR     = 4'b1000;

  localparam logic [2:0] FN_BAD    = 3'b111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;

  localparam logic [1:0] DST_RT    = 2'b00;
  localparam logic [1:0] DST_RD    = 2'b01;
  localparam logic [1:0] DST_LINK  = 2'b10;

  // Reset gates the whole decode so every output drops asynchronously with rst_n.
  always_comb begin
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    reg_dst    = DST_RT;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    jump       = 1'b0;
    jump_reg   = 1'b0;
    link       = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (opcode)
        OP_R_TYPE: begin
          if (funct == FN_BAD) begin
            illegal = 1'b1;
          end else begin
            reg_write = 1'b1;
            reg_dst   = DST_RD;
            alu_op    = {1'b0, funct};
          end
        end
        OP_ADDI: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
        end
        OP_LW: begin
          reg_write  = 1'b1;
          mem_read   = 1'b1;
          mem_to_reg = 1'b1;
          alu_src    = 1'b1;
        end
        OP_SW: begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
        end
        OP_BEQ: begin
          branch = 1'b1;
          alu_op = ALU_SUB;
        end
        OP_BNE: begin
          branch_ne = 1'b1;
          alu_op    = ALU_SUB;
        end
        OP_J: begin
          jump = 1'b1;
        end
        OP_JAL: begin
          jump      = 1'b1;
          link      = 1'b1;
          reg_write = 1'b1;
          reg_dst   = DST_LINK;
        end
        OP_JR: begin
          jump_reg = 1'b1;
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

  // An unknown illegal takes the else path of the if, so X inputs never set the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen <= 1'b0;
    end else if (illegal) begin
      illegal_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed sweep, random decode against a
// table-driven reference model, sticky-flag and asynchronous reset checks.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic [2:0] funct;
  logic       reg_write, mem_read, mem_write, mem_to_reg, alu_src;
  logic [3:0] alu_op;
  logic [1:0] reg_dst;
  logic       branch, branch_ne, jump, jump_reg, link, illegal, illegal_seen;

  int n_checks = 0;
  int n_pass   = 0;
  bit seen_model = 1'b0;

  // Control word layout: rw mr mw m2r asrc aluop[4] dst[2] br bne j jr lk ill
  logic [16:0] op_table [16];
  logic [16:0] dut_word;

  assign dut_word = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op, reg_dst,
                     branch, branch_ne, jump, jump_reg, link, illegal};

  control_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct        (funct),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .reg_dst      (reg_dst),
    .branch       (branch),
    .branch_ne    (branch_ne),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .link         (link),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] cw(input bit rw, mr, mw, m2r, asrc, input logic [3:0] aop,
                                     input logic [1:0] dst, input bit br, bne, j, jr, lk, ill);
    return {rw, mr, mw, m2r, asrc, aop, dst, br, bne, j, jr, lk, ill};
  endfunction

  function automatic logic [16:0] model(input logic [3:0] op, input logic [2:0] fn, input bit rst_on);
    if (!rst_on) return '0;
    if (op == 4'd0) begin
      if (fn == 3'd7) return cw(0,0,0,0,0,4'd0,2'd0,0,0,0,0,0,1);
      return cw(1,0,0,0,0,{1'b0, fn},2'd1,0,0,0,0,0,0);
    end
    return op_table[op];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic apply_and_check(input logic [3:0] op, input logic [2:0] fn, input string tag);
    @(negedge clk);
    opcode = op;
    funct  = fn;
    #1;
    chk(tag, {15'd0, dut_word}, {15'd0, model(op, fn, 1'b1)});
    chk({tag, "_excl"}, {30'd0, 2'(32'(branch) + 32'(branch_ne) + 32'(jump) + 32'(jump_reg) > 1)}, 32'd0);
    chk({tag, "_rwmw"}, {31'd0, reg_write & mem_write}, 32'd0);
    @(posedge clk);
    if (model(op, fn, 1'b1) & 17'd1) seen_model = 1'b1;
    #1;
    chk({tag, "_seen"}, {31'd0, illegal_seen}, {31'd0, seen_model});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) op_table[i] = cw(0,0,0,0,0,4'd0,2'd0,0,0,0,0,0,1);
    op_table[1] = cw(1,0,0,0,1,4'd0,2'd0,0,0,0,0,0,0);
    op_table[2] = cw(1,1,0,1,1,4'd0,2'd0,0,0,0,0,0,0);
    op_table[3] = cw(0,0,1,0,1,4'd0,2'd0,0,0,0,0,0,0);
    op_table[4] = cw(0,0,0,0,0,4'd1,2'd0,1,0,0,0,0,0);
    op_table[5] = cw(0,0,0,0,0,4'd1,2'd0,0,1,0,0,0,0);
    op_table[6] = cw(0,0,0,0,0,4'd0,2'd0,0,0,1,0,0,0);
    op_table[7] = cw(1,0,0,0,0,4'd0,2'd2,0,0,1,0,1,0);
    op_table[8] = cw(0,0,0,0,0,4'd0,2'd0,0,0,0,1,0,0);

    rst_n  = 1'b0;
    opcode = 4'b1111;
    funct  = 3'b111;
    #12;
    chk("reset_outputs", {15'd0, dut_word}, 32'd0);
    chk("reset_seen", {31'd0, illegal_seen}, 32'd0);
    opcode = 4'd2;
    funct  = 3'd0;
    #1;
    chk("reset_lw_outputs", {15'd0, dut_word}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int f = 0; f < 7; f++) apply_and_check(4'd0, 3'(f), $sformatf("rtype_fn%0d", f));
    for (int op = 1; op < 9; op++) apply_and_check(4'(op), 3'($urandom_range(7)), $sformatf("legal_op%0d", op));
    chk("seen_after_legal", {31'd0, illegal_seen}, 32'd0);

    apply_and_check(4'b1111, 3'd0, "illegal_op15");
    apply_and_check(4'd0, 3'd7, "illegal_fn7");
    apply_and_check(4'd0, 3'd0, "add_after_illegal");
    chk("seen_sticky", {31'd0, illegal_seen}, 32'd1);

    // Asynchronous reset mid-cycle while LW is on the bus.
    @(negedge clk);
    opcode = 4'd2;
    funct  = 3'd5;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {15'd0, dut_word}, 32'd0);
    chk("async_rst_seen", {31'd0, illegal_seen}, 32'd0);
    seen_model = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("release_lw", {15'd0, dut_word}, {15'd0, model(4'd2, 3'd5, 1'b1)});

    for (int k = 0; k < 200; k++) begin
      logic [3:0] op;
      op = (k < 150) ? 4'($urandom_range(8)) : 4'($urandom_range(15));
      apply_and_check(op, 3'($urandom_range(7)), $sformatf("rand%0d_op%0d", k, op));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
